// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
//
// Upstream stage of the matrix encoder. Bytes arrive over a valid/ready
// handshake, little-endian within a line, and every BYTES_PER_LINE bytes are
// packed into one LINE_W-bit line of a local line memory. Once all LINES
// lines are loaded the block fires a one-cycle start pulse, then serves the
// encoder's line reads and waits for its done before reopening for the next
// matrix.
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   in_data_i holds a valid byte
//   in_data_i    input byte, line byte 0 first
//   in_ready_o   loader can accept a byte (LOAD state)
//   enc_start_o  one-cycle start pulse to the encoder (FIRE state)
//   enc_done_i   encoder has finished the matrix (honoured in WAIT only)
//   cnt_value_i  line address requested by the encoder
//   line_in_o    line data for cnt_value_i, zero for out-of-range addresses
//   busy_o       high from the start pulse until done is accepted
//   lines_ld_o   lines stored so far in this matrix (LINES once complete)
// -----------------------------------------------------------------------------
module matrix_loader #(
  parameter int LINES          = 64,
  parameter int LINE_W         = 25,
  parameter int ADDR_W         = 7,
  parameter int BYTES_PER_LINE = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              enc_start_o,
  input  logic              enc_done_i,
  input  logic [ADDR_W-1:0] cnt_value_i,
  output logic [LINE_W-1:0] line_in_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] lines_ld_o
);

  // Widths derived from the parameters.
  localparam int IDX_W  = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int BC_W   = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
  localparam int ASM_W  = 8 * (BYTES_PER_LINE - 1);
  // Bits of the final byte that still fit into the line.
  localparam int TOP_W  = LINE_W - ASM_W;

  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(LINES - 1);
  localparam logic [ADDR_W-1:0] LINES_CNT = ADDR_W'(LINES);

  // FSM encoding.
  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_FIRE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q,    state_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] line_cnt_q, line_cnt_d;
  logic [ASM_W-1:0]  asm_q,      asm_d;

  // Line memory; deliberately has no reset.
  logic [LINE_W-1:0] mem [LINES];

  // ---------------------------------------------------------------------------
  // Transfer decode
  // ---------------------------------------------------------------------------
  logic              in_load;
  logic              xfer;
  logic              last_byte;
  logic              line_done;
  logic              matrix_done;
  logic [LINE_W-1:0] wr_data;

  assign in_load     = (state_q == ST_LOAD);
  // in_ready is exactly in_load, so the handshake reduces to this.
  assign xfer        = in_load & in_valid_i;
  assign last_byte   = (byte_cnt_q == LAST_BYTE);
  assign line_done   = xfer & last_byte;
  assign matrix_done = line_done & (line_cnt_q == LAST_LINE);

  // The last byte supplies only the top TOP_W bits of the line; its surplus
  // high bits are dropped here.
  assign wr_data = {in_data_i[TOP_W-1:0], asm_q};

  // ---------------------------------------------------------------------------
  // Assembly register: one byte lane per non-final byte position.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < BYTES_PER_LINE - 1; gi++) begin : g_lane
      logic lane_we;
      assign lane_we = xfer & (byte_cnt_q == BC_W'(gi));
      assign asm_d[8*gi +: 8] = lane_we ? in_data_i : asm_q[8*gi +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    line_cnt_d = line_cnt_q;

    case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          if (last_byte) begin
            byte_cnt_d = '0;
            if (matrix_done) begin
              // line_cnt parks at 0 so the next matrix starts at line 0.
              line_cnt_d = '0;
              state_d    = ST_FIRE;
            end else begin
              line_cnt_d = line_cnt_q + 1'b1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      // Single-cycle start pulse; any done seen here is ignored.
      ST_FIRE: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (enc_done_i) begin
          state_d = ST_LOAD;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_LOAD;
      byte_cnt_q <= '0;
      line_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      line_cnt_q <= line_cnt_d;
      asm_q      <= asm_d;
    end
  end

  // Memory write port.
  always_ff @(posedge clk_i) begin
    if (line_done) begin
      mem[line_cnt_q[IDX_W-1:0]] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational read port; out-of-range addresses read as zero so the
  // unwritten/nonexistent locations never leak X.
  // ---------------------------------------------------------------------------
  logic              addr_ok;
  logic [LINE_W-1:0] rd_data;

  assign addr_ok   = (cnt_value_i <= LAST_LINE);
  assign rd_data   = mem[cnt_value_i[IDX_W-1:0]];
  assign line_in_o = addr_ok ? rd_data : '0;

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only.
  // ---------------------------------------------------------------------------
  assign in_ready_o  = in_load;
  assign enc_start_o = (state_q == ST_FIRE);
  assign busy_o      = (state_q == ST_FIRE) | (state_q == ST_WAIT);
  assign lines_ld_o  = in_load ? line_cnt_q : LINES_CNT;

endmodule

// File: tb/tb_matrix_loader.sv
// -----------------------------------------------------------------------------
// tb_matrix_loader
//
// Self-checking bench for matrix_loader. A small byte-packing model turns the
// driven byte stream into expected lines, pushing each completed line onto a
// scoreboard queue; the queue is drained against the DUT read port once the
// matrix is loaded. Each scenario is a task called from one initial block.
// -----------------------------------------------------------------------------
module tb_matrix_loader;

  localparam int LINES  = 64;
  localparam int LINE_W = 25;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              enc_done = 1'b0;
  logic [ADDR_W-1:0] cnt_value = '0;
  logic              in_ready;
  logic              enc_start;
  logic              busy;
  logic [LINE_W-1:0] line_in;
  logic [ADDR_W-1:0] lines_ld;

  matrix_loader #(
    .LINES(LINES), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .BYTES_PER_LINE(4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .enc_start_o(enc_start),
    .enc_done_i (enc_done),
    .cnt_value_i(cnt_value),
    .line_in_o  (line_in),
    .busy_o     (busy),
    .lines_ld_o (lines_ld)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Counts cycles with enc_start high, sampled mid-cycle.
  int start_cnt = 0;
  always @(negedge clk) if (enc_start === 1'b1) start_cnt++;

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] m_asm;
  int          m_bcnt;
  int          m_lcnt;

  task automatic model_reset();
    m_asm  = '0;
    m_bcnt = 0;
    m_lcnt = 0;
    sb.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] t;
    exp_t        e;
    if (m_bcnt < 3) begin
      m_asm[8*m_bcnt +: 8] = b;
      m_bcnt++;
    end else begin
      t      = {b, m_asm};
      e.addr = ADDR_W'(m_lcnt);
      e.data = t[LINE_W-1:0];
      sb.push_back(e);
      m_bcnt = 0;
      m_lcnt = (m_lcnt + 1) % LINES;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus primitives (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b);
    int guard;
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      total++; bad++;
      $display("FAIL send_byte: in_ready=%b stayed low for %0d cycles, required 1", in_ready, guard);
    end else begin
      @(posedge clk); #1;
      model_byte(b);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    enc_done = 1'b0;
    #1 rst_n = 1'b0;
    #12;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%b exp=1", in_ready); end
    total++; if (enc_start !== 1'b0) begin bad++; $display("FAIL reset_enc_start: got=%b exp=0", enc_start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b exp=0", busy); end
    total++; if (lines_ld !== 7'd0) begin bad++; $display("FAIL reset_lines_ld: got=%0d exp=0", lines_ld); end
    $display("test_reset: in_ready=%b enc_start=%b busy=%b lines_ld=%0d", in_ready, enc_start, busy, lines_ld);
  endtask

  task automatic test_single_line();
    exp_t e;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'hFF);
    idle(1);
    cnt_value = 7'd0;
    #1;
    total++; if (line_in !== 25'h1030201) begin bad++; $display("FAIL line0_const: got=%h exp=1030201", line_in); end
    total++; if (lines_ld !== 7'd1) begin bad++; $display("FAIL line0_lines_ld: got=%0d exp=1", lines_ld); end
    e = sb.pop_front();
    total++; if (line_in !== e.data || e.addr !== 7'd0) begin bad++; $display("FAIL line0_model: got=%h exp=%h addr=%0d", line_in, e.data, e.addr); end
    $display("test_single_line: line0=%h lines_ld=%0d", line_in, lines_ld);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   base;
    time  t0;
    do_reset();
    base = start_cnt;
    t0   = $time;
    for (int i = 0; i < LINES * 4; i++) send_byte(8'(i * 37 + 11));
    // Now just after the edge of the 256th transfer.
    total++; if (($time - t0) / 10 !== 256) begin bad++; $display("FAIL b2b_throughput: got=%0d cycles exp=256", ($time - t0) / 10); end
    total++; if (enc_start !== 1'b1) begin bad++; $display("FAIL b2b_start_high: got=%b exp=1", enc_start); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_fire: got=%b exp=0", in_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_fire: got=%b exp=1", busy); end
    total++; if (lines_ld !== 7'd64) begin bad++; $display("FAIL b2b_lines_ld: got=%0d exp=64", lines_ld); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (enc_start !== 1'b0) begin bad++; $display("FAIL b2b_start_low: got=%b exp=0", enc_start); end
    total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_wait: ready=%b busy=%b exp 0/1", in_ready, busy); end
    total++; if (start_cnt - base !== 1) begin bad++; $display("FAIL b2b_start_count: got=%0d exp=1", start_cnt - base); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cnt_value = e.addr;
      #1;
      total++; if (line_in !== e.data) begin bad++; $display("FAIL b2b_read line=%0d: got=%h exp=%h", e.addr, line_in, e.data); end
    end
    $display("test_back_to_back: start pulses=%0d busy=%b", start_cnt - base, busy);
  endtask

  task automatic test_gapped();
    exp_t e;
    do_reset();
    for (int i = 0; i < LINES * 4; i++) begin
      send_byte(8'($urandom));
      idle(1);
    end
    // In WAIT: hold valid with changing data; nothing may be stored.
    in_valid = 1'b1;
    repeat (10) begin
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL gap_wait: ready=%b busy=%b exp 0/1", in_ready, busy); end
    total++; if (sb.size() !== LINES) begin bad++; $display("FAIL gap_sb_size: got=%0d exp=%0d", sb.size(), LINES); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cnt_value = e.addr;
      #1;
      total++; if (line_in !== e.data) begin bad++; $display("FAIL gap_read line=%0d: got=%h exp=%h", e.addr, line_in, e.data); end
    end
    for (int a = LINES; a < 128; a++) begin
      cnt_value = ADDR_W'(a);
      #1;
      total++; if (line_in !== '0) begin bad++; $display("FAIL gap_oob addr=%0d: got=%h exp=0", a, line_in); end
    end
    $display("test_gapped: golden image and out-of-range reads compared");
  endtask

  task automatic test_done_handling();
    exp_t e;
    // Leave the WAIT state left behind by the previous scenario.
    @(posedge clk); #1;
    enc_done = 1'b1;
    @(posedge clk); #1;
    enc_done = 1'b0;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL done_release: ready=%b busy=%b exp 1/0", in_ready, busy); end
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < LINES * 4; i++) send_byte(8'(i * 13 + m * 101 + 5));
      in_valid = 1'b0;
      // In FIRE now: this done must be ignored.
      enc_done = 1'b1;
      @(posedge clk); #1;
      enc_done = 1'b0;
      total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL done_in_fire m=%0d: busy=%b ready=%b exp 1/0", m, busy, in_ready); end
      while (sb.size() > 0) begin
        e = sb.pop_front();
        cnt_value = e.addr;
        #1;
        total++; if (line_in !== e.data) begin bad++; $display("FAIL done_read m=%0d line=%0d: got=%h exp=%h", m, e.addr, line_in, e.data); end
      end
      @(posedge clk); #1;
      repeat (4) begin @(posedge clk); #1; end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL done_still_busy m=%0d: got=%b exp=1", m, busy); end
      enc_done = 1'b1;
      @(posedge clk); #1;
      enc_done = 1'b0;
      total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL done_accept m=%0d: ready=%b busy=%b exp 1/0", m, in_ready, busy); end
      total++; if (lines_ld !== 7'd0 || enc_start !== 1'b0) begin bad++; $display("FAIL done_lines_ld m=%0d: lines_ld=%0d start=%b exp 0/0", m, lines_ld, enc_start); end
      $display("test_done_handling: matrix %0d loaded, done accepted, lines_ld=%0d", m, lines_ld);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   base;
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i));
    in_valid = 1'b0;
    total++; if (lines_ld !== 7'd1) begin bad++; $display("FAIL mid_before: lines_ld=%0d exp=1", lines_ld); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (lines_ld !== 7'd0) begin bad++; $display("FAIL mid_async: lines_ld=%0d exp=0", lines_ld); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    base = start_cnt;
    send_byte(8'h5A);
    send_byte(8'hC3);
    send_byte(8'h96);
    send_byte(8'h0E);
    in_valid = 1'b0;
    total++; if (lines_ld !== 7'd1) begin bad++; $display("FAIL mid_lines_ld: got=%0d exp=1", lines_ld); end
    e = sb.pop_front();
    cnt_value = e.addr;
    #1;
    total++; if (line_in !== e.data || line_in !== 25'h096C35A) begin bad++; $display("FAIL mid_line0: got=%h exp=%h", line_in, e.data); end
    for (int i = 4; i < LINES * 4 - 1; i++) send_byte(8'($urandom));
    total++; if (start_cnt - base !== 0 || enc_start !== 1'b0) begin bad++; $display("FAIL mid_early_start: pulses=%0d start=%b exp 0/0", start_cnt - base, enc_start); end
    send_byte(8'h77);
    in_valid = 1'b0;
    total++; if (enc_start !== 1'b1) begin bad++; $display("FAIL mid_start: got=%b exp=1", enc_start); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cnt_value = e.addr;
      #1;
      total++; if (line_in !== e.data) begin bad++; $display("FAIL mid_read line=%0d: got=%h exp=%h", e.addr, line_in, e.data); end
    end
    $display("test_reset_mid: restart at line 0, start after 256 bytes");
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_line();
    test_back_to_back();
    test_gapped();
    test_done_handling();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
